// File: rtl/list_packer_pkg.sv
// rtl/list_packer_pkg.sv - shared element type, default list length and packer state enumeration
package list_packer_pkg;

  localparam int INTEGER_WIDTH     = 8;
  localparam int MAX_EMBEDDING_DIM = 4;

  typedef logic signed [2*INTEGER_WIDTH-1:0] elem_t;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/list_packer.sv
// rtl/list_packer.sv - packs a stream of signed elements into fixed-length lists
// Optional short-list zero padding on last_in is enabled by defining LIST_PACKER_ZERO_PAD_EN.
module list_packer
  import list_packer_pkg::*;
#(
  parameter  int LIST_LEN = MAX_EMBEDDING_DIM,
  parameter  int W        = 2*INTEGER_WIDTH,
  localparam int CW       = $clog2(LIST_LEN+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_in,
  output logic                rdy_out,
  input  logic signed [W-1:0] elem_in,
  input  logic                last_in,
  output logic                vld_out,
  input  logic                rdy_in,
  output logic signed [W-1:0] list_out [0:LIST_LEN-1],
  output logic [CW-1:0]       count_out
);

  state_t              state_q;
  logic [CW-1:0]       idx_q;
  logic [CW-1:0]       count_q;
  logic                vld_q;
  logic signed [W-1:0] list_q [0:LIST_LEN-1];
  logic                pad;
  logic                last_elem;

`ifdef LIST_PACKER_ZERO_PAD_EN
  assign pad = last_in;
`else
  logic unused_last_in;
  assign unused_last_in = last_in;
  assign pad            = 1'b0;
`endif

  assign last_elem = (idx_q == CW'(LIST_LEN-1)) || pad;

  // While FULL the slot frees up in the same cycle the list leaves, so no bubble.
  assign rdy_out   = (state_q == FILL) || rdy_in;
  assign vld_out   = vld_q;
  assign count_out = count_q;
  assign list_out  = list_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      count_q <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < LIST_LEN; i++) begin
        list_q[i] <= '0;
      end
    end else begin
      case (state_q)
        FILL: begin
          if (vld_in) begin
            for (int i = 0; i < LIST_LEN; i++) begin
              if (CW'(i) == idx_q) begin
                list_q[i] <= elem_in;
              end else if (pad && (CW'(i) > idx_q)) begin
                list_q[i] <= '0;
              end
            end
            if (last_elem) begin
              state_q <= FULL;
              vld_q   <= 1'b1;
              idx_q   <= '0;
              count_q <= CW'(LIST_LEN);
            end else begin
              idx_q   <= idx_q + CW'(1);
              count_q <= idx_q + CW'(1);
            end
          end
        end
        FULL: begin
          if (rdy_in) begin
            state_q <= FILL;
            vld_q   <= 1'b0;
            if (vld_in) begin
              list_q[0] <= elem_in;
              idx_q     <= CW'(1);
              count_q   <= CW'(1);
            end else begin
              idx_q     <= '0;
              count_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= FILL;
          vld_q   <= 1'b0;
          idx_q   <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/list_packer.md
LIST_PACKER -- requirements
Module: list_packer

Interface
REQ-001 Parameter LIST_LEN, default `MAX_EMBEDDING_DIM, shall set the number of elements per packed list; it shall be at least 2.
REQ-002 Parameter W, default 2*`INTEGER_WIDTH, shall set the signed element width.
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  shall be the asynchronous, active-high reset.
REQ-005 vld_in  input  1  shall indicate that the upstream element is valid.
REQ-006 rdy_out  output  1  shall indicate that the block accepts an element this cycle.
REQ-007 elem_in  input  W (signed)  shall carry the streamed element.
REQ-008 last_in  input  1  shall mark the final element of a short list; it is qualified by vld_in.
REQ-009 vld_out  output  1  shall indicate that list_out holds a complete list.
REQ-010 rdy_in  input  1  shall indicate downstream acceptance.
REQ-011 list_out  output  W x [0:LIST_LEN-1] (signed, unpacked)  shall carry the packed list.
REQ-012 count_out  output  $clog2(LIST_LEN+1)  shall carry the number of elements written to the current list.

Function
REQ-013 An element transfer shall occur when vld_in && rdy_out; a list transfer shall occur when vld_out && rdy_in.
REQ-014 The block shall have two states:
- FILL: vld_out=0, rdy_out=1.
- FULL: vld_out=1, rdy_out=rdy_in.
REQ-015 In FILL, each element transfer shall write elem_in to list[idx] and increment idx by 1.
REQ-016 A transfer with idx==LIST_LEN-1 shall enter FULL next cycle, so vld_out rises exactly 1 cycle after the last element transfer.
REQ-017 In FULL with rdy_in=0, list_out, count_out and vld_out shall hold stable, and no element shall be accepted.
REQ-018 In FULL with rdy_in=1 and no element transfer, the list shall drain, with idx=0 and count_out=0 next cycle, and the state shall go to FILL.
REQ-019 In FULL, a list transfer and an element transfer in the same cycle shall:
- drain the current list;
- write elem_in to list[0];
- set idx=1;
- go to FILL.
No bubble shall be inserted.
REQ-020 list_out shall be driven directly from the internal registers with no combinational path from elem_in.
REQ-021 count_out shall equal idx in FILL and LIST_LEN in FULL.
REQ-022 Elements shall be stored without width change or arithmetic; list[i] shall equal the i-th accepted element of that list.

Reset
REQ-023 When rst is asserted, at any time including mid-fill or while FULL, the block shall immediately:
- clear all list entries to 0;
- set idx=0 and state=FILL;
- drive vld_out=0, count_out=0 and rdy_out=1 once rst deasserts.
REQ-024 Any partially packed list shall be discarded on reset.

Configuration
REQ-025 When macro LIST_PACKER_ZERO_PAD_EN is defined, an element transfer with last_in=1 in FILL shall:
- write elem_in to list[idx];
- write 0 to list[idx+1..LIST_LEN-1];
- enter FULL next cycle, with count_out=LIST_LEN.
REQ-026 When LIST_PACKER_ZERO_PAD_EN is defined, last_in=1 on the LIST_LEN-th element shall behave identically to last_in=0.
REQ-027 When LIST_PACKER_ZERO_PAD_EN is undefined, last_in shall be ignored, and no zero-fill logic shall be synthesized.

Structure
REQ-028 The element type, the default LIST_LEN and the state enumeration (FILL, FULL) shall reside in the shared package included via include/sys_defs.svh.
REQ-029 The block shall be a single module with no sub-modules; its list_out/vld_out/rdy_in side shall connect directly to the list_in/vld_in/rdy_out side of the reduction stage.

Verification
REQ-030 The bench (LIST_LEN=4, W=16) shall cover the following scenarios:
- Basic fill: stream 1,-2,3,-4 back-to-back with rdy_in=1 -> vld_out=1 one cycle after the 4th transfer; list_out={1,-2,3,-4}; vld_out=0 the following cycle.
- Backpressure: hold rdy_in=0 for 5 cycles while FULL with vld_in=1 -> rdy_out=0; list_out stable; no element lost; next list starts with the held element after rdy_in=1.
- Continuous stream: 8 consecutive elements 10..17 with rdy_in=1 -> lists {10,11,12,13} then {14,15,16,17}; element 14 accepted in the drain cycle; zero idle cycles.
- Reset mid-fill: assert rst after 2 elements, then stream 5,6,7,8 -> single list {5,6,7,8}; count_out=0 right after reset.
- Zero pad (LIST_PACKER_ZERO_PAD_EN defined): stream 9, then 7 with last_in=1 -> list_out={9,7,0,0} and count_out=4.
- Zero pad (LIST_PACKER_ZERO_PAD_EN undefined): repeat the same stimulus -> no vld_out until 4 elements have been accepted.
